// File: rtl/fetch_pc_seq.sv
// fetch_pc_seq: fetch-stage PC sequencer for a Y86-style pipeline.
// Holds the current fetch PC and chooses the next one from the fetched
// instruction, stalls, mispredict redirects and resolved return targets.
// Tracks a run/ret-wait/halted/fault state, an architectural status code
// and a count of the instructions it has issued.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   stall_i                      hold PC, suppress issue
//   icode_i, ifun_i              fetched instruction code / function
//   valC_i, valP_i               fetched constant / fall-through address
//   instr_valid_i, imem_error_i  fetch validity / instruction memory error
//   mispredict_i, mispredict_pc_i  redirect request and corrected PC
//   ret_valid_i, ret_pc_i        resolved return target
//   PC_o         registered current fetch PC
//   issue_o      combinational: instruction at PC_o goes downstream now
//   stat_o       registered status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   state_o      registered state (0 RUN, 1 RET_WAIT, 2 HALTED, 3 FAULT)
//   issue_cnt_o  registered issued-instruction count (wraps)
module fetch_pc_seq #(
  parameter int unsigned       ADDR_W        = 64,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter bit                PREDICT_TAKEN = 1'b1,
  parameter int unsigned       CNT_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ifun_i,
  input  logic [ADDR_W-1:0] valC_i,
  input  logic [ADDR_W-1:0] valP_i,
  input  logic              instr_valid_i,
  input  logic              imem_error_i,
  input  logic              mispredict_i,
  input  logic [ADDR_W-1:0] mispredict_pc_i,
  input  logic              ret_valid_i,
  input  logic [ADDR_W-1:0] ret_pc_i,
  output logic [ADDR_W-1:0] PC_o,
  output logic              issue_o,
  output logic [2:0]        stat_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  issue_cnt_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_RET_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED   = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] F_JMP  = 4'h0;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Issue only from RUN with a clean, unstalled, unredirected fetch.
  assign issue_o = (state_q == ST_RUN) & ~rst_i & ~mispredict_i & ~stall_i &
                   instr_valid_i & ~imem_error_i;

  // Next-state / next-PC selection; mispredict overrides every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;

    if (mispredict_i) begin
      pc_d    = mispredict_pc_i;
      state_d = ST_RUN;
      stat_d  = STAT_AOK;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall_i) begin
            // Memory error wins over an invalid-instruction indication.
            if (imem_error_i) begin
              state_d = ST_FAULT;
              stat_d  = STAT_ADR;
            end else if (!instr_valid_i) begin
              state_d = ST_FAULT;
              stat_d  = STAT_INS;
            end else begin
              case (icode_i)
                I_HALT: begin
                  state_d = ST_HALTED;
                  stat_d  = STAT_HLT;
                end
                I_JXX: begin
                  if (ifun_i == F_JMP || PREDICT_TAKEN) pc_d = valC_i;
                  else                                  pc_d = valP_i;
                end
                I_CALL:  pc_d    = valC_i;
                I_RET:   state_d = ST_RET_WAIT;
                default: pc_d    = valP_i;
              endcase
            end
          end
        end
        ST_RET_WAIT: begin
          // Return target resolution is not subject to stall.
          if (ret_valid_i) begin
            pc_d    = ret_pc_i;
            state_d = ST_RUN;
          end
        end
        default: begin
          // HALTED and FAULT hold until redirect or reset.
        end
      endcase
    end

    if (issue_o) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_o        = pc_q;
  assign stat_o      = stat_q;
  assign state_o     = state_q;
  assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_pc_seq.sv
// tb_fetch_pc_seq: scoreboard bench for fetch_pc_seq.
// Two instances share all inputs: dut (defaults: predict taken, RESET_PC 0,
// 32-bit counter) and dut2 (predict not-taken, RESET_PC 0x100, 4-bit
// counter). Their state/stat/issue behaviour is identical; only the PC
// after reset or a conditional jump and the counter width differ.
module tb_fetch_pc_seq;

  typedef struct packed {
    logic        rst;
    logic        mp;
    logic [63:0] mp_pc;
    logic        rv;
    logic [63:0] rv_pc;
    logic        stall;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        valid;
    logic        err;
  } stim_t;

  typedef struct packed {
    logic        issue;
    logic [63:0] pc;
    logic [63:0] pc2;
    logic [1:0]  state;
    logic [2:0]  stat;
    logic [31:0] cnt;
    logic [3:0]  cnt2;
  } exp_t;

  logic        clk;
  logic        rst, stall, ivalid, ierr, mp, rv;
  logic [3:0]  icode, ifun;
  logic [63:0] valc, valp, mp_pc, rv_pc;
  logic [63:0] pc, pc2;
  logic        issue, issue2;
  logic [2:0]  stat, stat2;
  logic [1:0]  state, state2;
  logic [31:0] cnt;
  logic [3:0]  cnt2;

  stim_t stim_q[$];
  exp_t  pend_q[$];
  exp_t  sb[$];
  exp_t  obs;
  exp_t  e;
  logic        obs_issue2;
  logic [1:0]  obs_state2;
  logic [2:0]  obs_stat2;
  int          passed = 0;
  int          total  = 0;

  fetch_pc_seq dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .icode_i(icode), .ifun_i(ifun),
    .valC_i(valc), .valP_i(valp), .instr_valid_i(ivalid), .imem_error_i(ierr),
    .mispredict_i(mp), .mispredict_pc_i(mp_pc), .ret_valid_i(rv), .ret_pc_i(rv_pc),
    .PC_o(pc), .issue_o(issue), .stat_o(stat), .state_o(state), .issue_cnt_o(cnt)
  );

  fetch_pc_seq #(
    .ADDR_W(64), .RESET_PC(64'h100), .PREDICT_TAKEN(1'b0), .CNT_W(4)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .icode_i(icode), .ifun_i(ifun),
    .valC_i(valc), .valP_i(valp), .instr_valid_i(ivalid), .imem_error_i(ierr),
    .mispredict_i(mp), .mispredict_pc_i(mp_pc), .ret_valid_i(rv), .ret_pc_i(rv_pc),
    .PC_o(pc2), .issue_o(issue2), .stat_o(stat2), .state_o(state2), .issue_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  // Plain valid instruction with no side-band activity.
  function automatic stim_t ins(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] c, input logic [63:0] p);
    stim_t s;
    s = '0;
    s.icode = ic; s.ifun = fn; s.valc = c; s.valp = p; s.valid = 1'b1;
    return s;
  endfunction

  task automatic push(input stim_t s, input logic is, input logic [63:0] p,
                      input logic [63:0] p2, input logic [1:0] st,
                      input logic [2:0] sa, input logic [31:0] c);
    exp_t x;
    x.issue = is; x.pc = p; x.pc2 = p2; x.state = st; x.stat = sa;
    x.cnt = c; x.cnt2 = 4'(c);
    stim_q.push_back(s);
    pend_q.push_back(x);
  endtask

  // Drive the next stimulus for one cycle and capture both instances.
  task automatic execute();
    stim_t s;
    s = stim_q.pop_front();
    sb.push_back(pend_q.pop_front());
    @(negedge clk);
    rst = s.rst; mp = s.mp; mp_pc = s.mp_pc; rv = s.rv; rv_pc = s.rv_pc;
    stall = s.stall; icode = s.icode; ifun = s.ifun; valc = s.valc;
    valp = s.valp; ivalid = s.valid; ierr = s.err;
    #1;
    obs.issue  = issue;
    obs_issue2 = issue2;
    @(posedge clk);
    #1;
    obs.pc = pc; obs.pc2 = pc2; obs.state = state; obs.stat = stat;
    obs.cnt = cnt; obs.cnt2 = cnt2;
    obs_state2 = state2; obs_stat2 = stat2;
  endtask

  task automatic test_reset();
    stim_t s;
    s = ins(4'h3, 4'h0, 64'h0, 64'h55);
    s.rst = 1'b1; s.mp = 1'b1; s.mp_pc = 64'h77; s.rv = 1'b1;
    push(s, 1'b0, 64'h0, 64'h100, 2'd0, 3'd1, 32'd0);
    push(s, 1'b0, 64'h0, 64'h100, 2'd0, 3'd1, 32'd0);
    while (stim_q.size() > 0) begin
      execute();
      e = sb.pop_front();
      total++;
      if (obs !== e || {obs_issue2, obs_state2, obs_stat2} !== {e.issue, e.state, e.stat})
        $display("FAIL reset #%0d: got %h/%h/%h want %h", total, obs, obs_state2, obs_stat2, e);
      else passed++;
    end
  endtask

  task automatic test_sequential();
    stim_t s;
    push(ins(4'h3, 4'h0, 64'h0, 64'd10), 1'b1, 64'd10, 64'd10, 2'd0, 3'd1, 32'd1);
    s = ins(4'h3, 4'h0, 64'h0, 64'd99); s.stall = 1'b1;
    push(s, 1'b0, 64'd10, 64'd10, 2'd0, 3'd1, 32'd1);
    push(ins(4'h6, 4'h1, 64'h0, 64'd20), 1'b1, 64'd20, 64'd20, 2'd0, 3'd1, 32'd2);
    while (stim_q.size() > 0) begin
      execute();
      e = sb.pop_front();
      total++;
      if (obs !== e || {obs_issue2, obs_state2, obs_stat2} !== {e.issue, e.state, e.stat})
        $display("FAIL sequential #%0d: got %h/%h/%h want %h", total, obs, obs_state2, obs_stat2, e);
      else passed++;
    end
  endtask

  task automatic test_branch();
    stim_t s;
    push(ins(4'h7, 4'h1, 64'h40, 64'd29), 1'b1, 64'h40, 64'd29, 2'd0, 3'd1, 32'd3);
    s = ins(4'h3, 4'h0, 64'h0, 64'h66); s.mp = 1'b1; s.mp_pc = 64'd29; s.stall = 1'b1;
    push(s, 1'b0, 64'd29, 64'd29, 2'd0, 3'd1, 32'd3);
    push(ins(4'h7, 4'h0, 64'h30, 64'h31), 1'b1, 64'h30, 64'h30, 2'd0, 3'd1, 32'd4);
    push(ins(4'h8, 4'h0, 64'h40, 64'h39), 1'b1, 64'h40, 64'h40, 2'd0, 3'd1, 32'd5);
    while (stim_q.size() > 0) begin
      execute();
      e = sb.pop_front();
      total++;
      if (obs !== e || {obs_issue2, obs_state2, obs_stat2} !== {e.issue, e.state, e.stat})
        $display("FAIL branch #%0d: got %h/%h/%h want %h", total, obs, obs_state2, obs_stat2, e);
      else passed++;
    end
  endtask

  task automatic test_ret();
    stim_t s;
    push(ins(4'h9, 4'h0, 64'h0, 64'h41), 1'b1, 64'h40, 64'h40, 2'd1, 3'd1, 32'd6);
    for (int i = 0; i < 3; i++) begin
      s = ins(4'h3, 4'h0, 64'h0, 64'h99); s.stall = 1'(i);
      push(s, 1'b0, 64'h40, 64'h40, 2'd1, 3'd1, 32'd6);
    end
    s = ins(4'h3, 4'h0, 64'h0, 64'h99); s.rv = 1'b1; s.rv_pc = 64'h80; s.stall = 1'b1;
    push(s, 1'b0, 64'h80, 64'h80, 2'd0, 3'd1, 32'd6);
    s = ins(4'h3, 4'h0, 64'h0, 64'h88); s.rv = 1'b1; s.rv_pc = 64'h500;
    push(s, 1'b1, 64'h88, 64'h88, 2'd0, 3'd1, 32'd7);
    while (stim_q.size() > 0) begin
      execute();
      e = sb.pop_front();
      total++;
      if (obs !== e || {obs_issue2, obs_state2, obs_stat2} !== {e.issue, e.state, e.stat})
        $display("FAIL ret #%0d: got %h/%h/%h want %h", total, obs, obs_state2, obs_stat2, e);
      else passed++;
    end
  endtask

  task automatic test_halt_fault();
    stim_t s;
    push(ins(4'h0, 4'h0, 64'h0, 64'h99), 1'b1, 64'h88, 64'h88, 2'd2, 3'd2, 32'd8);
    push(ins(4'h3, 4'h0, 64'h0, 64'h99), 1'b0, 64'h88, 64'h88, 2'd2, 3'd2, 32'd8);
    s = ins(4'h3, 4'h0, 64'h0, 64'h99); s.rv = 1'b1; s.rv_pc = 64'h123;
    push(s, 1'b0, 64'h88, 64'h88, 2'd2, 3'd2, 32'd8);
    s = ins(4'h0, 4'h0, 64'h0, 64'h99); s.mp = 1'b1; s.mp_pc = 64'h90;
    push(s, 1'b0, 64'h90, 64'h90, 2'd0, 3'd1, 32'd8);
    s = ins(4'h3, 4'h0, 64'h0, 64'h99); s.err = 1'b1;
    push(s, 1'b0, 64'h90, 64'h90, 2'd3, 3'd3, 32'd8);
    s = ins(4'h3, 4'h0, 64'h0, 64'h99); s.rv = 1'b1; s.rv_pc = 64'h124;
    push(s, 1'b0, 64'h90, 64'h90, 2'd3, 3'd3, 32'd8);
    s = ins(4'h3, 4'h0, 64'h0, 64'h99); s.rst = 1'b1; s.mp = 1'b1; s.mp_pc = 64'h555;
    push(s, 1'b0, 64'h0, 64'h100, 2'd0, 3'd1, 32'd0);
    while (stim_q.size() > 0) begin
      execute();
      e = sb.pop_front();
      total++;
      if (obs !== e || {obs_issue2, obs_state2, obs_stat2} !== {e.issue, e.state, e.stat})
        $display("FAIL halt_fault #%0d: got %h/%h/%h want %h", total, obs, obs_state2, obs_stat2, e);
      else passed++;
    end
  endtask

  task automatic test_faults_and_reset_abandon();
    stim_t s;
    s = ins(4'h3, 4'h0, 64'h0, 64'h44); s.valid = 1'b0;
    push(s, 1'b0, 64'h0, 64'h100, 2'd3, 3'd4, 32'd0);
    s = ins(4'h3, 4'h0, 64'h0, 64'h44); s.mp = 1'b1; s.mp_pc = 64'h10;
    push(s, 1'b0, 64'h10, 64'h10, 2'd0, 3'd1, 32'd0);
    s = ins(4'h3, 4'h0, 64'h0, 64'h44); s.stall = 1'b1; s.err = 1'b1;
    push(s, 1'b0, 64'h10, 64'h10, 2'd0, 3'd1, 32'd0);
    s = ins(4'h3, 4'h0, 64'h0, 64'h44); s.valid = 1'b0; s.err = 1'b1;
    push(s, 1'b0, 64'h10, 64'h10, 2'd3, 3'd3, 32'd0);
    s = ins(4'h3, 4'h0, 64'h0, 64'h44); s.mp = 1'b1; s.mp_pc = 64'h20;
    push(s, 1'b0, 64'h20, 64'h20, 2'd0, 3'd1, 32'd0);
    push(ins(4'h9, 4'h0, 64'h0, 64'h21), 1'b1, 64'h20, 64'h20, 2'd1, 3'd1, 32'd1);
    s = ins(4'h3, 4'h0, 64'h0, 64'h44); s.rst = 1'b1; s.rv = 1'b1; s.rv_pc = 64'h777;
    push(s, 1'b0, 64'h0, 64'h100, 2'd0, 3'd1, 32'd0);
    s = ins(4'h3, 4'h0, 64'h0, 64'd8); s.rv = 1'b1; s.rv_pc = 64'h777;
    push(s, 1'b1, 64'd8, 64'd8, 2'd0, 3'd1, 32'd1);
    while (stim_q.size() > 0) begin
      execute();
      e = sb.pop_front();
      total++;
      if (obs !== e || {obs_issue2, obs_state2, obs_stat2} !== {e.issue, e.state, e.stat})
        $display("FAIL faults #%0d: got %h/%h/%h want %h", total, obs, obs_state2, obs_stat2, e);
      else passed++;
    end
  endtask

  task automatic test_counter_wrap();
    stim_t s;
    s = ins(4'h3, 4'h0, 64'h0, 64'h0); s.rst = 1'b1;
    push(s, 1'b0, 64'h0, 64'h100, 2'd0, 3'd1, 32'd0);
    for (int i = 1; i <= 16; i++)
      push(ins(4'h3, 4'h0, 64'h0, 64'(4 * i)), 1'b1, 64'(4 * i), 64'(4 * i),
           2'd0, 3'd1, 32'(i));
    while (stim_q.size() > 0) begin
      execute();
      e = sb.pop_front();
      total++;
      if (obs !== e || {obs_issue2, obs_state2, obs_stat2} !== {e.issue, e.state, e.stat})
        $display("FAIL counter #%0d: got %h/%h/%h want %h", total, obs, obs_state2, obs_stat2, e);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; icode = '0; ifun = '0; valc = '0; valp = '0;
    ivalid = 1'b0; ierr = 1'b0; mp = 1'b0; mp_pc = '0; rv = 1'b0; rv_pc = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_ret();
    test_halt_fault();
    test_faults_and_reset_abandon();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
